// File: rtl/fifo_pkg.sv
// Shared types and helpers for the register-file FIFO family.
package fifo_pkg;

    // Storage depth for a given pointer width.
    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    // Status bundle as presented to the configuration-register bank.
    typedef struct packed {
        logic overflow;
        logic underflow;
        logic almost_full;
        logic almost_empty;
        logic full;
        logic empty;
    } fifo_status_t;

endpackage

// File: rtl/reg_sp_rf.sv
// Register file: one synchronous write port and one asynchronous read port.
// Contents are deliberately not reset.
module reg_sp_rf #(
    parameter int DATA_W_P = 64,
    parameter int ADDR_W_P = 5,
    parameter int DEPTH_P  = 32
) (
    input  logic                clk,
    input  logic                we_i,
    input  logic [ADDR_W_P-1:0] waddr_i,
    input  logic [DATA_W_P-1:0] wdata_i,
    input  logic [ADDR_W_P-1:0] raddr_i,
    output logic [DATA_W_P-1:0] rdata_o
);

    logic [DATA_W_P-1:0] mem_q [DEPTH_P];

    // Write port.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_register_flags.sv
// Synchronous FWFT FIFO with programmable thresholds, sticky error status,
// high-water mark and flush.
module fifo_register_flags
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH_P = 64,
    parameter int ADDR_WIDTH_P = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ing_enable,
    input  logic [DATA_WIDTH_P-1:0] ing_data,
    output logic                    ing_full,
    output logic                    ing_almost_full,
    input  logic                    egr_enable,
    output logic [DATA_WIDTH_P-1:0] egr_data,
    output logic                    egr_empty,
    output logic                    egr_almost_empty,
    input  logic                    cmd_flush,
    input  logic                    cmd_clear_status,
    input  logic [ADDR_WIDTH_P:0]   cr_almost_full_lvl,
    input  logic [ADDR_WIDTH_P:0]   cr_almost_empty_lvl,
    output logic [ADDR_WIDTH_P:0]   sr_fill_level,
    output logic [ADDR_WIDTH_P:0]   sr_max_fill,
    output logic                    sr_overflow,
    output logic                    sr_underflow
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH_P);
    localparam int FW    = ADDR_WIDTH_P + 1;

    logic [ADDR_WIDTH_P-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]           fill_q, fill_d, max_q, max_d;
    logic                    empty_q, empty_d, ovf_q, ovf_d, unf_q, unf_d;
    logic                    full, write_en, read_en, mem_we;
    fifo_status_t            status;

    // Full is the MSB of occupancy; it can only be set when depth words are held.
    assign full     = fill_q[ADDR_WIDTH_P];
    assign write_en = ing_enable & ~full;
    assign read_en  = egr_enable & ~empty_q;
    // A flushed write is lost; nothing lands in storage during reset either.
    assign mem_we   = write_en & ~cmd_flush & rst_n;

    reg_sp_rf #(
        .DATA_W_P (DATA_WIDTH_P),
        .ADDR_W_P (ADDR_WIDTH_P),
        .DEPTH_P  (DEPTH)
    ) u_rf (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (ing_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (egr_data)
    );

    // Next state for pointers, occupancy, sticky status and watermark.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        empty_d  = empty_q;
        max_d    = max_q;
        if (cmd_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
            empty_d  = 1'b1;
        end else begin
            if (write_en) wr_ptr_d = wr_ptr_q + ADDR_WIDTH_P'(1);
            if (read_en)  rd_ptr_d = rd_ptr_q + ADDR_WIDTH_P'(1);
            fill_d = fill_q + FW'(write_en) - FW'(read_en);
            if (write_en && !read_en)
                empty_d = 1'b0;
            else if (read_en && !write_en && fill_q == FW'(1))
                empty_d = 1'b1;
        end
        // Set events are OR'd in after the clear so they win.
        ovf_d = (cmd_clear_status ? 1'b0 : ovf_q) | (ing_enable & full);
        unf_d = (cmd_clear_status ? 1'b0 : unf_q) | (egr_enable & empty_q);
        if (cmd_clear_status)
            max_d = fill_d;
        else if (fill_d > max_q)
            max_d = fill_d;
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
            max_q    <= '0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
            max_q    <= max_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Threshold flags compare the registered fill directly, no added latency.
    always_comb begin
        status.overflow     = ovf_q;
        status.underflow    = unf_q;
        status.almost_full  = (fill_q >= cr_almost_full_lvl);
        status.almost_empty = (fill_q <= cr_almost_empty_lvl);
        status.full         = full;
        status.empty        = empty_q;
    end

    assign ing_full         = status.full;
    assign ing_almost_full  = status.almost_full;
    assign egr_empty        = status.empty;
    assign egr_almost_empty = status.almost_empty;
    assign sr_overflow      = status.overflow;
    assign sr_underflow     = status.underflow;
    assign sr_fill_level    = fill_q;
    assign sr_max_fill      = max_q;

endmodule

// File: tb/tb_fifo_register_flags.sv
// Directed bench for fifo_register_flags at depth 4, 8-bit data.
module tb_fifo_register_flags;

    localparam int DW = 8;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ing_enable, egr_enable, cmd_flush, cmd_clear_status;
    logic [DW-1:0] ing_data, egr_data;
    logic          ing_full, ing_almost_full, egr_empty, egr_almost_empty;
    logic [AW:0]   cr_almost_full_lvl, cr_almost_empty_lvl;
    logic [AW:0]   sr_fill_level, sr_max_fill;
    logic          sr_overflow, sr_underflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fifo_register_flags #(.DATA_WIDTH_P(DW), .ADDR_WIDTH_P(AW)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .ing_enable          (ing_enable),
        .ing_data            (ing_data),
        .ing_full            (ing_full),
        .ing_almost_full     (ing_almost_full),
        .egr_enable          (egr_enable),
        .egr_data            (egr_data),
        .egr_empty           (egr_empty),
        .egr_almost_empty    (egr_almost_empty),
        .cmd_flush           (cmd_flush),
        .cmd_clear_status    (cmd_clear_status),
        .cr_almost_full_lvl  (cr_almost_full_lvl),
        .cr_almost_empty_lvl (cr_almost_empty_lvl),
        .sr_fill_level       (sr_fill_level),
        .sr_max_fill         (sr_max_fill),
        .sr_overflow         (sr_overflow),
        .sr_underflow        (sr_underflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ing_enable = 1'b0; egr_enable = 1'b0;
        cmd_flush = 1'b0; cmd_clear_status = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d);
        ing_enable = 1'b1; ing_data = d;
        step();
        ing_enable = 1'b0;
    endtask

    task automatic pop(input logic [DW-1:0] exp_d, input string tag);
        chk(tag, egr_data, exp_d);
        egr_enable = 1'b1;
        step();
        egr_enable = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; ing_data = '0; idle();
        cr_almost_full_lvl = 3'd3; cr_almost_empty_lvl = 3'd1;
        step(); step();
        chk("rst_fill", sr_fill_level, 0);
        chk("rst_empty", egr_empty, 1);
        chk("rst_full", ing_full, 0);
        chk("rst_max", sr_max_fill, 0);
        chk("rst_ovf", sr_overflow, 0);
        chk("rst_unf", sr_underflow, 0);
        chk("rst_ae", egr_almost_empty, 1);
        chk("rst_af", ing_almost_full, 0);
        rst_n = 1'b1;

        // Fill
        push(8'h11);
        chk("w1_fill", sr_fill_level, 1);
        chk("w1_empty", egr_empty, 0);
        chk("w1_head", egr_data, 8'h11);
        chk("w1_ae", egr_almost_empty, 1);
        push(8'h22);
        chk("w2_ae", egr_almost_empty, 0);
        chk("w2_af", ing_almost_full, 0);
        push(8'h33);
        chk("w3_af", ing_almost_full, 1);
        chk("w3_full", ing_full, 0);
        push(8'h44);
        chk("w4_full", ing_full, 1);
        chk("w4_max", sr_max_fill, 4);

        // Overflow
        push(8'h99);
        chk("ovf_fill", sr_fill_level, 4);
        chk("ovf_flag", sr_overflow, 1);

        // Drain
        pop(8'h11, "r1_data"); chk("r1_fill", sr_fill_level, 3);
        pop(8'h22, "r2_data"); chk("r2_ae", egr_almost_empty, 0);
        pop(8'h33, "r3_data"); chk("r3_ae", egr_almost_empty, 1);
        pop(8'h44, "r4_data");
        chk("r4_empty", egr_empty, 1);
        chk("r4_fill", sr_fill_level, 0);

        // Underflow
        egr_enable = 1'b1; step(); egr_enable = 1'b0;
        chk("unf_flag", sr_underflow, 1);
        chk("unf_fill", sr_fill_level, 0);

        // Clear status
        cmd_clear_status = 1'b1; step(); cmd_clear_status = 1'b0;
        chk("clr_ovf", sr_overflow, 0);
        chk("clr_unf", sr_underflow, 0);
        chk("clr_max", sr_max_fill, 0);

        // Simultaneous at empty: only the write happens
        ing_enable = 1'b1; egr_enable = 1'b1; ing_data = 8'hA1;
        step(); idle();
        chk("se_fill", sr_fill_level, 1);
        chk("se_head", egr_data, 8'hA1);
        chk("se_unf", sr_underflow, 1);

        push(8'hB2); push(8'hC3); push(8'hD4);
        chk("sf_full", ing_full, 1);
        // Simultaneous at full: only the read happens
        ing_enable = 1'b1; egr_enable = 1'b1; ing_data = 8'hEE;
        step(); idle();
        chk("sf_fill", sr_fill_level, 3);
        chk("sf_head", egr_data, 8'hB2);
        chk("sf_ovf", sr_overflow, 1);
        pop(8'hB2, "sm_pre");
        // Simultaneous mid-level
        ing_enable = 1'b1; egr_enable = 1'b1; ing_data = 8'hF1;
        step(); idle();
        chk("sm_fill", sr_fill_level, 2);
        chk("sm_head", egr_data, 8'hD4);
        pop(8'hD4, "sm_d1");
        pop(8'hF1, "sm_d2");
        chk("sm_empty", egr_empty, 1);

        // Streaming across pointer wrap at steady fill 2
        push(8'h60); push(8'h61);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("wr_data%0d", i), egr_data, 8'h60 + i);
            ing_enable = 1'b1; egr_enable = 1'b1; ing_data = 8'h62 + i;
            step();
            chk($sformatf("wr_fill%0d", i), sr_fill_level, 2);
            chk($sformatf("wr_flags%0d", i),
                {ing_full, egr_empty, ing_almost_full, egr_almost_empty}, 0);
        end
        idle();
        pop(8'h6A, "wr_tail0");
        pop(8'h6B, "wr_tail1");
        chk("wr_empty", egr_empty, 1);

        // Flush with concurrent write
        push(8'h71); push(8'h72); push(8'h73);
        chk("fl_pre", sr_fill_level, 3);
        cmd_flush = 1'b1; ing_enable = 1'b1; ing_data = 8'h77;
        step(); idle();
        chk("fl_fill", sr_fill_level, 0);
        chk("fl_empty", egr_empty, 1);
        chk("fl_max", sr_max_fill, 4);
        push(8'h5A);
        chk("fl_head", egr_data, 8'h5A);
        chk("fl_fill1", sr_fill_level, 1);

        // Reset mid-operation
        push(8'h5B);
        chk("rs_pre_fill", sr_fill_level, 2);
        chk("rs_pre_ovf", sr_overflow, 1);
        rst_n = 1'b0;
        #2;
        chk("rs_between", sr_fill_level, 2);
        step();
        rst_n = 1'b1;
        chk("rs_fill", sr_fill_level, 0);
        chk("rs_empty", egr_empty, 1);
        chk("rs_ovf", sr_overflow, 0);
        chk("rs_unf", sr_underflow, 0);
        chk("rs_max", sr_max_fill, 0);
        chk("rs_full", ing_full, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
